// File: rtl/mem_stage_pkg.sv
// Shared encodings, widths and the MEM/WB payload type for the memory stage.
package mem_stage_pkg;

    localparam int unsigned DW   = 32;  // data word width
    localparam int unsigned AW   = 30;  // word address width
    localparam int unsigned RW   = 5;   // register address width
    localparam int unsigned OPW  = 2;   // memory / control op width
    localparam int unsigned EXPW = 3;   // exception code width

    // Memory operation encoding; the reserved code behaves like NOP.
    typedef enum logic [OPW-1:0] {
        MEMOP_NOP   = 2'b00,
        MEMOP_LOAD  = 2'b01,
        MEMOP_STORE = 2'b10,
        MEMOP_RSVD  = 2'b11
    } mem_op_e;

    localparam logic [EXPW-1:0] NO_EXP     = 3'h0;
    localparam logic [EXPW-1:0] MISS_ALIGN = 3'h4;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // MEM/WB pipeline register payload.
    typedef struct packed {
        logic [AW-1:0]   pc;
        logic            en;
        logic            br_flag;
        logic [OPW-1:0]  ctrl_op;
        logic [RW-1:0]   dst_addr;
        logic            gpr_we_;
        logic [EXPW-1:0] exp_code;
        logic [DW-1:0]   out;
    } mem_wb_t;

    // Bubble contents used by both reset (pc=0) and flush (pc kept).
    function automatic mem_wb_t wb_cleared(input logic [AW-1:0] pc);
        mem_wb_t w;
        w          = '0;
        w.pc       = pc;
        w.gpr_we_  = 1'b1;
        w.exp_code = NO_EXP;
        return w;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory-stage control: alignment check, bus FSM, bus drive and result mux.
module mem_ctrl
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   ex_pc,
    input  logic            ex_en,
    input  logic            ex_br_flag,
    input  logic [OPW-1:0]  ex_mem_op,
    input  logic [DW-1:0]   ex_mem_wr_data,
    input  logic [OPW-1:0]  ex_ctrl_op,
    input  logic [RW-1:0]   ex_dst_addr,
    input  logic            ex_gpr_we_,
    input  logic [EXPW-1:0] ex_exp_code,
    input  logic [DW-1:0]   ex_out,
    input  logic [DW-1:0]   bus_rd_data,
    input  logic            bus_rdy,
    output logic            busy_c,
    output logic            bus_req_c,
    output logic            bus_rw_c,
    output logic [AW-1:0]   bus_addr_c,
    output logic [DW-1:0]   bus_wr_data_c,
    output mem_wb_t         wb_next_c
);

    mem_state_e state_q;
    mem_state_e state_d;
    mem_op_e    op;
    logic       is_load;
    logic       is_store;
    logic       misalign;
    logic       access;

    // Decode the op and qualify the bus access.
    always_comb begin
        op       = mem_op_e'(ex_mem_op);
        is_load  = (op == MEMOP_LOAD);
        is_store = (op == MEMOP_STORE);
        misalign = ex_en & (is_load | is_store) & (ex_out[1:0] != 2'b00);
        access   = ex_en & (is_load | is_store) & (ex_exp_code == NO_EXP)
                   & (ex_out[1:0] == 2'b00);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request and busy; a started request is held until rdy,
    // and reset drops request/busy without waiting for a clock edge.
    always_comb begin
        state_d   = state_q;
        bus_req_c = 1'b0;
        busy_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    bus_req_c = 1'b1;
                    if (!bus_rdy) begin
                        busy_c  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                bus_req_c = 1'b1;
                if (bus_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!reset) begin
            bus_req_c = 1'b0;
            busy_c    = 1'b0;
        end
    end

    // Bus address/data come straight from EX, which the stall keeps stable.
    always_comb begin
        bus_rw_c      = is_load ? BUS_READ : BUS_WRITE;
        bus_addr_c    = ex_out[DW-1:2];
        bus_wr_data_c = ex_mem_wr_data;
    end

    // Value the MEM/WB register would capture this cycle (before flush).
    always_comb begin
        wb_next_c          = '0;
        wb_next_c.pc       = ex_pc;
        wb_next_c.en       = ex_en;
        wb_next_c.br_flag  = ex_br_flag;
        wb_next_c.ctrl_op  = ex_ctrl_op;
        wb_next_c.dst_addr = ex_dst_addr;
        wb_next_c.gpr_we_  = ex_gpr_we_ | ~ex_en | is_store | misalign;
        wb_next_c.exp_code = misalign ? MISS_ALIGN : ex_exp_code;
        wb_next_c.out      = is_load ? bus_rd_data : ex_out;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: bus control plus the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    output logic            busy,
    output logic [DW-1:0]   fwd_data,
    input  logic [AW-1:0]   ex_pc,
    input  logic            ex_en,
    input  logic            ex_br_flag,
    input  logic [OPW-1:0]  ex_mem_op,
    input  logic [DW-1:0]   ex_mem_wr_data,
    input  logic [OPW-1:0]  ex_ctrl_op,
    input  logic [RW-1:0]   ex_dst_addr,
    input  logic            ex_gpr_we_,
    input  logic [EXPW-1:0] ex_exp_code,
    input  logic [DW-1:0]   ex_out,
    output logic            bus_req,
    output logic            bus_rw,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wr_data,
    input  logic [DW-1:0]   bus_rd_data,
    input  logic            bus_rdy,
    output logic [AW-1:0]   mem_pc,
    output logic            mem_en,
    output logic            mem_br_flag,
    output logic [OPW-1:0]  mem_ctrl_op,
    output logic [RW-1:0]   mem_dst_addr,
    output logic            mem_gpr_we_,
    output logic [EXPW-1:0] mem_exp_code,
    output logic [DW-1:0]   mem_out
);

    mem_wb_t wb_next_c;
    mem_wb_t wb_q;
    logic    busy_c;
    logic    hold;
    logic    flush_pend_q;

    mem_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .ex_pc          (ex_pc),
        .ex_en          (ex_en),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out),
        .bus_rd_data    (bus_rd_data),
        .bus_rdy        (bus_rdy),
        .busy_c         (busy_c),
        .bus_req_c      (bus_req),
        .bus_rw_c       (bus_rw),
        .bus_addr_c     (bus_addr),
        .bus_wr_data_c  (bus_wr_data),
        .wb_next_c      (wb_next_c)
    );

    assign busy     = busy_c;
    assign hold     = busy_c | stall;
    assign fwd_data = wb_next_c.out;

    // MEM/WB register; a flush seen while holding is remembered so the
    // in-flight result is discarded once the register next updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q         <= wb_cleared(AW'(0));
            flush_pend_q <= 1'b0;
        end else if (hold) begin
            flush_pend_q <= flush_pend_q | flush;
        end else begin
            flush_pend_q <= 1'b0;
            if (flush | flush_pend_q) begin
                wb_q <= wb_cleared(ex_pc);
            end else begin
                wb_q <= wb_next_c;
            end
        end
    end

    // Break the register out onto the named pipeline outputs.
    always_comb begin
        mem_pc       = wb_q.pc;
        mem_en       = wb_q.en;
        mem_br_flag  = wb_q.br_flag;
        mem_ctrl_op  = wb_q.ctrl_op;
        mem_dst_addr = wb_q.dst_addr;
        mem_gpr_we_  = wb_q.gpr_we_;
        mem_exp_code = wb_q.exp_code;
        mem_out      = wb_q.out;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, corner sequences, random run.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, busy;
    logic [31:0] fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic        bus_req, bus_rw, bus_rdy;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .fwd_data(fwd_data), .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
        .ex_out(ex_out), .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    // One EX-stage instruction as presented to the stage.
    typedef struct packed {
        logic        en;
        logic [1:0]  op;
        logic [29:0] pc;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] out;
        logic [31:0] wr;
    } instr_t;

    // Expected MEM/WB contents.
    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] out;
    } wb_t;

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [31:0] out, wr, rd;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic        x_req, x_rw;
        logic [29:0] x_addr;
        logic [31:0] x_out;
        logic        x_we_;
        logic [2:0]  x_exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input instr_t i);
        ex_en = i.en; ex_mem_op = i.op; ex_pc = i.pc; ex_br_flag = i.br;
        ex_ctrl_op = i.ctrl; ex_dst_addr = i.dst; ex_gpr_we_ = i.we_;
        ex_exp_code = i.exp; ex_out = i.out; ex_mem_wr_data = i.wr;
    endtask

    function automatic instr_t mk(input logic en, input logic [1:0] op, input logic [29:0] pc,
                                  input logic [31:0] out, input logic [31:0] wr,
                                  input logic [4:0] dst, input logic we_, input logic [2:0] exp);
        instr_t i;
        i = '{en: en, op: op, pc: pc, br: pc[0], ctrl: pc[2:1], dst: dst, we_: we_,
              exp: exp, out: out, wr: wr};
        return i;
    endfunction

    // Reference rules: a bus access needs a valid, aligned, exception-free load or store.
    function automatic logic wants_bus(input instr_t i);
        return i.en && (i.op == 2'd1 || i.op == 2'd2) && i.exp == 3'd0 && i.out[1:0] == 2'd0;
    endfunction

    function automatic wb_t bubble(input logic [29:0] pc);
        wb_t w;
        w = '{pc: pc, en: 1'b0, br: 1'b0, ctrl: 2'd0, dst: 5'd0, we_: 1'b1, exp: 3'd0, out: 32'd0};
        return w;
    endfunction

    function automatic wb_t result_of(input instr_t i, input logic [31:0] rd);
        wb_t w;
        logic bad_align;
        bad_align = i.en && (i.op == 2'd1 || i.op == 2'd2) && i.out[1:0] != 2'd0;
        w.pc = i.pc; w.en = i.en; w.br = i.br; w.ctrl = i.ctrl; w.dst = i.dst;
        w.out = (i.op == 2'd1) ? rd : i.out;
        w.exp = bad_align ? 3'd4 : i.exp;
        if (!i.en || i.op == 2'd2 || bad_align) w.we_ = 1'b1;
        else                                     w.we_ = i.we_;
        return w;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        logic [31:0] r;
        r = $urandom;
        i.en = ($urandom_range(0, 7) != 0);
        i.op = 2'($urandom_range(0, 3));
        i.pc = 30'($urandom);
        i.br = r[0]; i.ctrl = r[2:1]; i.dst = r[7:3]; i.we_ = r[8];
        i.exp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        i.out = $urandom;
        if ($urandom_range(0, 3) != 0) i.out[1:0] = 2'd0;
        i.wr = $urandom;
        return i;
    endfunction

    function automatic wb_t dut_wb();
        wb_t w;
        w = '{pc: mem_pc, en: mem_en, br: mem_br_flag, ctrl: mem_ctrl_op, dst: mem_dst_addr,
              we_: mem_gpr_we_, exp: mem_exp_code, out: mem_out};
        return w;
    endfunction

    task automatic check_wb(input string name, input wb_t exp);
        check(name, 128'(dut_wb()), 128'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t cur;
        wb_t    model;
        logic   flush_seen, take_new, acc, busy_x, hold_x;

        //                en   op    ex_out        wr         rd            dst  we_ exp  req  rw  addr       out           we_ exp
        vecs[0] = '{1'b1, 2'd1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd5, 1'b0, 3'd0, 1'b1, 1'b1, 30'h40, 32'hDEAD_BEEF, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 2'd0, 32'h0000_0055, 32'h0, 32'hAAAA_5555, 5'd3, 1'b0, 3'd0, 1'b0, 1'b0, 30'h0,  32'h0000_0055, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 2'd1, 32'h0000_0102, 32'h0, 32'h1111_2222, 5'd7, 1'b0, 3'd0, 1'b0, 1'b0, 30'h0,  32'h1111_2222, 1'b1, 3'd4};
        vecs[3] = '{1'b1, 2'd2, 32'h0000_0020, 32'h1234, 32'h99,     5'd9, 1'b0, 3'd0, 1'b1, 1'b0, 30'h8,  32'h0000_0020, 1'b1, 3'd0};
        vecs[4] = '{1'b1, 2'd3, 32'h0000_0077, 32'h0, 32'h5,         5'd2, 1'b0, 3'd0, 1'b0, 1'b0, 30'h0,  32'h0000_0077, 1'b0, 3'd0};
        vecs[5] = '{1'b0, 2'd1, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 5'd4, 1'b0, 3'd0, 1'b0, 1'b0, 30'h0,  32'hCAFE_F00D, 1'b1, 3'd0};
        vecs[6] = '{1'b1, 2'd1, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 5'd6, 1'b0, 3'd2, 1'b0, 1'b0, 30'h0,  32'h0BAD_F00D, 1'b0, 3'd2};
        vecs[7] = '{1'b1, 2'd2, 32'h0000_0021, 32'h77, 32'h0,        5'd1, 1'b0, 3'd0, 1'b0, 1'b0, 30'h0,  32'h0000_0021, 1'b1, 3'd4};
        vecs[8] = '{1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0, 32'h3,         5'd31, 1'b1, 3'd0, 1'b0, 1'b0, 30'h0, 32'hFFFF_FFFC, 1'b1, 3'd0};

        reset = 1'b0; stall = 1'b0; flush = 1'b0; bus_rdy = 1'b1; bus_rd_data = '0;
        apply(mk(1'b0, 2'd0, 30'h0, 32'h0, 32'h0, 5'd0, 1'b1, 3'd0));
        repeat (2) @(posedge clk);
        #1;
        check_wb("reset_values", bubble(30'h0));
        check("reset_busy", 128'(busy), 128'(1'b0));
        @(negedge clk) reset = 1'b1;

        // Single-cycle vectors with a zero-wait bus.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            apply(mk(vecs[v].en, vecs[v].op, 30'(32'h1000 + v), vecs[v].out, vecs[v].wr,
                     vecs[v].dst, vecs[v].we_, vecs[v].exp));
            bus_rdy = 1'b1; bus_rd_data = vecs[v].rd;
            #1;
            check($sformatf("v%0d_req", v), 128'(bus_req), 128'(vecs[v].x_req));
            check($sformatf("v%0d_busy", v), 128'(busy), 128'(1'b0));
            check($sformatf("v%0d_fwd", v), 128'(fwd_data), 128'(vecs[v].x_out));
            if (vecs[v].x_req) begin
                check($sformatf("v%0d_rw", v), 128'(bus_rw), 128'(vecs[v].x_rw));
                check($sformatf("v%0d_addr", v), 128'(bus_addr), 128'(vecs[v].x_addr));
                check($sformatf("v%0d_wdata", v), 128'(bus_wr_data), 128'(vecs[v].wr));
            end
            @(posedge clk); #1;
            check($sformatf("v%0d_out", v), 128'(mem_out), 128'(vecs[v].x_out));
            check($sformatf("v%0d_we", v), 128'(mem_gpr_we_), 128'(vecs[v].x_we_));
            check($sformatf("v%0d_exp", v), 128'(mem_exp_code), 128'(vecs[v].x_exp));
            check($sformatf("v%0d_en", v), 128'(mem_en), 128'(vecs[v].en));
            check($sformatf("v%0d_dst", v), 128'(mem_dst_addr), 128'(vecs[v].dst));
            check($sformatf("v%0d_pc", v), 128'(mem_pc), 128'(32'h1000 + v));
        end

        // Store with three wait states: register holds, then captures.
        apply(mk(1'b1, 2'd2, 30'h2000, 32'h20, 32'h1234, 5'd0, 1'b0, 3'd0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus_rdy = 1'b0; #1;
            check($sformatf("st_busy%0d", k), 128'(busy), 128'(1'b1));
            check($sformatf("st_req%0d", k), 128'(bus_req), 128'(1'b1));
            check($sformatf("st_rw%0d", k), 128'(bus_rw), 128'(1'b0));
            check($sformatf("st_addr%0d", k), 128'(bus_addr), 128'(30'h8));
            check($sformatf("st_wdata%0d", k), 128'(bus_wr_data), 128'(32'h1234));
            @(posedge clk); #1;
            check($sformatf("st_hold%0d", k), 128'(mem_out), 128'(32'hFFFF_FFFC));
        end
        @(negedge clk); bus_rdy = 1'b1; #1;
        check("st_done_busy", 128'(busy), 128'(1'b0));
        check("st_done_req", 128'(bus_req), 128'(1'b1));
        @(posedge clk); #1;
        check_wb("st_result", '{pc: 30'h2000, en: 1'b1, br: 1'b0, ctrl: 2'd0, dst: 5'd0,
                                we_: 1'b1, exp: 3'd0, out: 32'h20});

        // Flush in the second cycle of a three-wait load discards the result.
        apply(mk(1'b1, 2'd1, 30'h123, 32'h300, 32'h0, 5'd8, 1'b0, 3'd0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus_rdy = 1'b0; flush = (k == 1); #1;
            check($sformatf("fl_req%0d", k), 128'(bus_req), 128'(1'b1));
            check($sformatf("fl_busy%0d", k), 128'(busy), 128'(1'b1));
            @(posedge clk);
        end
        @(negedge clk); flush = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h5A5A_5A5A; #1;
        check("fl_done_req", 128'(bus_req), 128'(1'b1));
        @(posedge clk); #1;
        check_wb("fl_result", bubble(30'h123));
        @(negedge clk);
        apply(mk(1'b1, 2'd0, 30'h124, 32'h55, 32'h0, 5'd3, 1'b0, 3'd0));
        @(posedge clk); #1;
        check_wb("fl_after", '{pc: 30'h124, en: 1'b1, br: 1'b0, ctrl: 2'd2, dst: 5'd3,
                               we_: 1'b0, exp: 3'd0, out: 32'h55});

        // Asynchronous reset while waiting on the bus.
        @(negedge clk);
        apply(mk(1'b1, 2'd1, 30'h400, 32'h400, 32'h0, 5'd9, 1'b0, 3'd0));
        bus_rdy = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check("rst_req", 128'(bus_req), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check_wb("rst_wb", bubble(30'h0));
        @(negedge clk); ex_en = 1'b0;
        @(negedge clk); reset = 1'b1;

        // Randomised run; EX inputs are held whenever the stage holds, like a stalled pipeline.
        model = bubble(30'h0);
        flush_seen = 1'b0;
        take_new = 1'b1;
        cur = rand_instr();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (take_new) cur = rand_instr();
            apply(cur);
            bus_rdy = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            bus_rd_data = $urandom;
            #1;
            acc = wants_bus(cur);
            busy_x = acc & ~bus_rdy;
            check("rnd_busy", 128'(busy), 128'(busy_x));
            check("rnd_req", 128'(bus_req), 128'(acc));
            if (acc) check("rnd_addr", 128'(bus_addr), 128'(cur.out[31:2]));
            check("rnd_fwd", 128'(fwd_data), 128'((cur.op == 2'd1) ? bus_rd_data : cur.out));
            hold_x = busy_x | stall;
            flush_seen = flush_seen | flush;
            @(posedge clk); #1;
            if (!hold_x) begin
                model = flush_seen ? bubble(cur.pc) : result_of(cur, bus_rd_data);
                flush_seen = 1'b0;
            end
            take_new = !hold_x;
            check_wb("rnd_wb", model);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the EX pipeline register outputs and performs data-memory load/store through a single-outstanding request/ready bus.
- Checks alignment and registers results into the MEM/WB pipeline register.
- Asserts busy to stall the pipeline while a bus access is pending, and forwards the memory-stage result to ID.

Parameters:
- DW, 32, data word width.
- AW, 30, word address width (byte address = {addr, 2'b00}).
- RW, 5, register address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset. Polarity and synchronicity are fixed.
- stall  in  1  hold MEM/WB register.
- flush  in  1  invalidate MEM/WB register.
- busy  out  1  bus access pending; drives global stall.
- fwd_data  out  DW  combinational mem-stage result (load data or ex_out).
- ex_pc  in  AW  instruction PC.
- ex_en  in  1  instruction valid.
- ex_br_flag  in  1  delay-slot flag.
- ex_mem_op  in  2  00 NOP, 01 LOAD, 10 STORE, 11 reserved (treated as NOP).
- ex_mem_wr_data  in  DW  store data.
- ex_ctrl_op  in  2  control op, passed through.
- ex_dst_addr  in  RW  destination register.
- ex_gpr_we_  in  1  active-low GPR write enable.
- ex_exp_code  in  3  incoming exception code.
- ex_out  in  DW  ALU result / effective byte address.
- bus_req  out  1  access request.
- bus_rw  out  1  1 read, 0 write.
- bus_addr  out  AW  word address = ex_out[DW-1:2].
- bus_wr_data  out  DW  store data.
- bus_rd_data  in  DW  load data.
- bus_rdy  in  1  access complete.
- mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out  out  (widths as ex_*)  MEM/WB register.

Behaviour:
- Access condition: ex_en & (LOAD|STORE) & ex_exp_code==NO_EXP & ex_out[1:0]==0.
- Misalignment: ex_en & (LOAD|STORE) & ex_out[1:0]!=0 -> no bus access; registered exp_code = MISS_ALIGN (3'h4); gpr_we_ forced 1.
- FSM with two states: IDLE, WAIT.
  - IDLE: if the access condition holds and bus_rdy=1 in the same cycle, the access completes with zero wait states and busy stays 0. If the access condition holds and bus_rdy=0, go to WAIT with busy=1.
  - WAIT: bus_req, bus_rw, bus_addr and bus_wr_data stay held from the EX inputs, which the pipeline stall keeps stable. On bus_rdy=1, busy=0 and return to IDLE.
- bus_req is combinational: high whenever the access condition holds in IDLE or WAIT.
- Once bus_req is asserted it is never withdrawn before bus_rdy. A flush arriving during WAIT does not abort the access; the result is discarded by the register flush.
- Result select: LOAD -> bus_rd_data; all other ops -> ex_out. STORE forces gpr_we_=1.
- MEM/WB register update priority (highest first):
  - reset: all outputs 0, except mem_gpr_we_=1 and mem_exp_code=NO_EXP.
  - busy or stall: hold.
  - flush: same values as reset, except mem_pc, which is taken from ex_pc.
  - otherwise: load the computed values.
- Latency: 1 cycle with zero-wait memory; 1+N cycles with N wait states.
- fwd_data equals the value that the register would capture this cycle.
- ex_en=0 -> register loads en=0, gpr_we_=1; no bus access.
- Asynchronous reset mid-WAIT -> FSM returns to IDLE and bus_req drops immediately. The bus slave must tolerate this.

Decomposition:
- Shared package/header holds: MEMOP encodings (NOP/LOAD/STORE), exception codes (NO_EXP, MISS_ALIGN), bus read/write encoding, and the width macros DW/AW/RW.
- Sub-module mem_ctrl: alignment check, FSM, bus drive, result mux.
- mem_stage top: mem_ctrl plus the MEM/WB register (mem_reg).

Test Plan:
- Load, zero-wait: ex_out=0x100, LOAD, bus_rdy=1, rd_data=0xDEADBEEF -> bus_addr=0x40, bus_rw=1; next cycle mem_out=0xDEADBEEF, mem_gpr_we_=0, busy never asserted.
- Store, 3 wait states: ex_out=0x20, STORE, wr_data=0x1234, rdy low for 3 cycles -> busy=1 for 3 cycles, bus_req held, bus_wr_data=0x1234; after rdy, mem_gpr_we_=1.
- Misaligned: LOAD with ex_out=0x102 -> bus_req=0; mem_exp_code=MISS_ALIGN, mem_gpr_we_=1.
- Flush during WAIT: flush=1 in cycle 2 of a 3-wait load -> bus_req stays high until rdy; after completion mem_en=0, mem_gpr_we_=1.
- Reset mid-WAIT: drive reset=0 asynchronously -> bus_req=0 and busy=0 without a clock edge; all mem_* at reset values.
- Pass-through: NOP with ex_out=0x55, dst=3, gpr_we_=0 -> mem_out=0x55, mem_dst_addr=3, fwd_data=0x55; no bus_req.
